// File: rtl/bootrom_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bootrom_arb_pkg
//  Purpose  : Shared types and constants for the boot-ROM arbiter.
//             - rsp_t        : response register {valid, idx, err}
//             - ROM_WORDS_DEFAULT, WORD_OFFSET, IDX_W
//  Config   : none here; BOOTROM_ARB_RR_EN is consumed by bootrom_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package bootrom_arb_pkg;

   localparam int ROM_WORDS_DEFAULT = 2048;

   // Byte address -> word address shift (32-bit words).
   localparam int WORD_OFFSET = 2;

   // Index field sized for the largest supported port count (8).
   localparam int IDX_W = 3;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
      logic             err;
   } rsp_t;

endpackage : bootrom_arb_pkg
`default_nettype wire

// File: rtl/bootrom_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module   : bootrom_arb_prio
//  Purpose  : Combinational rotating priority encoder. The request vector is
//             rotated so that ptr_i becomes position 0, the lowest set bit of
//             the rotated vector wins, and the winner is mapped back to an
//             absolute port index. ptr_i = 0 gives plain fixed priority.
//  Ports    : req_i   [N_PORTS-1:0]  request vector
//             ptr_i   [IW-1:0]       highest-priority index (< N_PORTS)
//             gnt_o   [N_PORTS-1:0]  one-hot grant
//             idx_o   [IW-1:0]       index of granted port
//             valid_o                any grant issued
//  Revision : 1.0 - initial release
// ============================================================================
module bootrom_arb_prio #(
   parameter int N_PORTS = 2,
   parameter int IW      = 1
) (
   input  logic [N_PORTS-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [N_PORTS-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               valid_o
);

   logic [2*N_PORTS-1:0] w_req2;
   logic [N_PORTS-1:0]   w_rot;
   logic [IW:0]          w_sum;

   // Doubling the vector makes the right shift behave as a rotation.
   assign w_req2 = {req_i, req_i};
   assign w_rot  = N_PORTS'(w_req2 >> ptr_i);

   always_comb begin
      valid_o = 1'b0;
      w_sum   = '0;
      // Descending scan: the last hit (lowest rotated position) wins.
      for (int j = N_PORTS - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            valid_o = 1'b1;
            w_sum   = {1'b0, ptr_i} + (IW+1)'(j);
         end
      end
      if (w_sum >= (IW+1)'(N_PORTS)) begin
         w_sum = w_sum - (IW+1)'(N_PORTS);
      end
      idx_o = w_sum[IW-1:0];
      gnt_o = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         gnt_o[k] = valid_o && (idx_o == IW'(k));
      end
   end

endmodule : bootrom_arb_prio
`default_nettype wire

// File: rtl/bootrom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bootrom_arbiter
//  Purpose  : Arbitrates N_PORTS read requesters onto one synchronous boot ROM.
//             Grants are combinational (same cycle as the request), responses
//             arrive exactly one cycle later on the granted port. Word
//             addresses at or beyond ROM_WORDS return err_o=1, rdata_o=0 and
//             never enable the ROM.
//  Config   : `define BOOTROM_ARB_RR_EN -> round-robin arbitration;
//             otherwise fixed priority, lowest index first.
//  Ports    : CLK, RSTN (async, active-low)
//             req_i  [N]          addr_i [N*ADDR_WIDTH] (port i at slice i)
//             gnt_o  [N] (comb)   rvalid_o [N] (registered)
//             rdata_o, err_o      shared response, qualified by rvalid_o
//             rom_cen_o (active-low), rom_addr_o, rom_rdata_i
//  Revision : 1.0 - initial release
// ============================================================================
module bootrom_arbiter
   import bootrom_arb_pkg::*;
#(
   parameter int N_PORTS    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ROM_WORDS  = ROM_WORDS_DEFAULT
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic [N_PORTS-1:0]            req_i,
   input  logic [N_PORTS*ADDR_WIDTH-1:0] addr_i,
   output logic [N_PORTS-1:0]            gnt_o,
   output logic [N_PORTS-1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          err_o,
   output logic                          rom_cen_o,
   output logic [$clog2(ROM_WORDS)-1:0]  rom_addr_o,
   input  logic [DATA_WIDTH-1:0]         rom_rdata_i
);

   localparam int ROM_AW = $clog2(ROM_WORDS);
   localparam int IW     = $clog2(N_PORTS);

   logic [N_PORTS-1:0]    w_req;
   logic [N_PORTS-1:0]    w_gnt;
   logic [IW-1:0]         w_idx;
   logic [IW-1:0]         w_ptr;
   logic                  w_any;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] w_word;
   logic                  w_in_range;
   logic                  w_rom_acc;

   logic [ROM_AW-1:0]     rom_addr_q;
   rsp_t                  rsp_q;
   rsp_t                  rsp_d;

   // Grants are combinational, so requests are masked while in reset to keep
   // gnt_o and the ROM interface quiet.
   assign w_req = req_i & {N_PORTS{RSTN}};

   bootrom_arb_prio #(
      .N_PORTS (N_PORTS),
      .IW      (IW)
   ) u_prio (
      .req_i   (w_req),
      .ptr_i   (w_ptr),
      .gnt_o   (w_gnt),
      .idx_o   (w_idx),
      .valid_o (w_any)
   );

`ifdef BOOTROM_ARB_RR_EN
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;

   // After granting port k, port k+1 (wrapping) gets top priority.
   always_comb begin
      ptr_d = ptr_q;
      if (w_any) begin
         ptr_d = (w_idx == IW'(N_PORTS - 1)) ? '0 : w_idx + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign w_ptr = ptr_q;
`else
   assign w_ptr = '0;
`endif

   // Select the granted port's address (one-hot grant, so OR-free mux).
   always_comb begin
      w_addr = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (w_gnt[i]) begin
            w_addr = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // Range check uses the full word address so high address bits count.
   assign w_word     = w_addr >> WORD_OFFSET;
   assign w_in_range = (w_word < ADDR_WIDTH'(ROM_WORDS));
   assign w_rom_acc  = w_any & w_in_range;

   assign gnt_o      = w_gnt;
   assign rom_cen_o  = ~w_rom_acc;
   // ROM address is live during an access and holds its last value otherwise.
   assign rom_addr_o = w_rom_acc ? w_addr[ROM_AW+WORD_OFFSET-1:WORD_OFFSET]
                                 : rom_addr_q;

   always_comb begin
      rsp_d       = '0;
      rsp_d.valid = w_any;
      rsp_d.idx   = IDX_W'(w_idx);
      rsp_d.err   = w_any & ~w_in_range;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rom_addr_q <= '0;
         rsp_q      <= '0;
      end else begin
         if (w_rom_acc) begin
            rom_addr_q <= rom_addr_o;
         end
         rsp_q <= rsp_d;
      end
   end

   // Response decode: rvalid_o is driven purely from the response register.
   always_comb begin
      rvalid_o = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         rvalid_o[i] = rsp_q.valid && (rsp_q.idx == IDX_W'(i));
      end
   end

   assign rdata_o = (rsp_q.valid && !rsp_q.err) ? rom_rdata_i : '0;
   assign err_o   = rsp_q.valid & rsp_q.err;

endmodule : bootrom_arbiter
`default_nettype wire

// File: tb/tb_bootrom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bootrom_arbiter
//  Purpose  : Self-checking bench for bootrom_arbiter (N_PORTS=2, defaults).
//             Directed steps followed by random traffic, all compared against
//             a cycle-level behavioural model of the arbitration rules.
//             Honours BOOTROM_ARB_RR_EN to select the expected policy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bootrom_arbiter;

   localparam int NP = 2;
`ifdef BOOTROM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [1:0]  req_i;
   logic [63:0] addr_i;
   logic [1:0]  gnt_o;
   logic [1:0]  rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        rom_cen_o;
   logic [10:0] rom_addr_o;
   logic [31:0] rom_rdata_i = 32'd0;

   int checks   = 0;
   int failures = 0;

   // Model state
   logic        m_valid;
   int          m_idx;
   logic        m_err;
   logic [10:0] m_word;
   logic [10:0] m_romaddr;
   int          m_ptr;

   bootrom_arbiter #(
      .N_PORTS    (NP),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .ROM_WORDS  (2048)
   ) dut (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .req_i       (req_i),
      .addr_i      (addr_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .rom_cen_o   (rom_cen_o),
      .rom_addr_o  (rom_addr_o),
      .rom_rdata_i (rom_rdata_i)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rom_fn(input logic [10:0] w);
      return 32'hB007_0000 ^ (32'(w) * 32'h0001_0003);
   endfunction

   // Synchronous ROM: data for an enabled access appears after the edge.
   always @(posedge CLK) begin
      if (!rom_cen_o) rom_rdata_i <= rom_fn(rom_addr_o);
   end

   function automatic int pick(input logic [1:0] req, input int ptr);
      int p;
      for (int i = 0; i < NP; i++) begin
         p = (ptr + i) % NP;
         if (req[p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0: return 32'h0000_2000 | ($urandom & 32'h0000_0FFF);
         1: return 32'h0000_1FFC | 32'($urandom_range(0, 3));
         2: return $urandom;
         default: return $urandom & 32'h0000_1FFF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_valid   = 1'b0;
      m_idx     = 0;
      m_err     = 1'b0;
      m_word    = '0;
      m_romaddr = '0;
      m_ptr     = 0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_gnt"},      {30'b0, gnt_o},      32'd0);
      check({tag, "_rvalid"},   {30'b0, rvalid_o},   32'd0);
      check({tag, "_rdata"},    rdata_o,             32'd0);
      check({tag, "_err"},      {31'b0, err_o},      32'd0);
      check({tag, "_rom_cen"},  {31'b0, rom_cen_o},  32'd1);
      check({tag, "_rom_addr"}, {21'b0, rom_addr_o}, 32'd0);
   endtask

   // One clock cycle: drive, compare against the model, advance the model.
   task automatic step(input logic [1:0] req, input logic [31:0] a0,
                       input logic [31:0] a1);
      int          g;
      logic [31:0] ga;
      logic        inr;
      logic        acc;
      logic [10:0] w;
      req_i  = req;
      addr_i = {a1, a0};
      g      = pick(req, RR ? m_ptr : 0);
      ga     = (g == 1) ? a1 : a0;
      inr    = ((ga >> 2) < 32'd2048);
      acc    = (g >= 0) && inr;
      w      = ga[12:2];
      #2;
      check("gnt",      {30'b0, gnt_o},      (g >= 0) ? (32'd1 << g) : 32'd0);
      check("rom_cen",  {31'b0, rom_cen_o},  {31'b0, ~acc});
      check("rom_addr", {21'b0, rom_addr_o}, acc ? {21'b0, w} : {21'b0, m_romaddr});
      check("rvalid",   {30'b0, rvalid_o},   m_valid ? (32'd1 << m_idx) : 32'd0);
      check("rdata",    rdata_o,             (m_valid && !m_err) ? rom_fn(m_word) : 32'd0);
      check("err",      {31'b0, err_o},      {31'b0, m_valid & m_err});
      @(posedge CLK);
      m_valid = (g >= 0);
      m_idx   = (g >= 0) ? g : 0;
      m_err   = !inr;
      m_word  = w;
      if (acc) m_romaddr = w;
      if (RR && g >= 0) m_ptr = (g + 1) % NP;
      #1;
   endtask

   initial begin
      model_reset();
      RSTN   = 1'b0;
      req_i  = 2'b11;
      addr_i = {32'h0000_0020, 32'h0000_0010};
      repeat (2) @(posedge CLK);
      #1;
      check_reset("reset");

      // First grant in the first cycle out of reset, addr 0x10 -> word 4.
      RSTN = 1'b1;
      step(2'b01, 32'h0000_0010, 32'h0);
      step(2'b00, 32'h0, 32'h0);

      // Continuous contention on both ports.
      repeat (6) step(2'b11, 32'h0000_0100, 32'h0000_0204);

      // Out of range (word 2048), then the last valid word on port 1.
      step(2'b01, 32'h0000_2000, 32'h0);
      step(2'b10, 32'h0, 32'h0000_1FFC);
      step(2'b00, 32'h0, 32'h0);

      // Reset pulse between a grant and its response.
      step(2'b01, 32'h0000_0040, 32'h0);
      RSTN  = 1'b0;
      req_i = 2'b11;
      #2;
      check_reset("midreset");
      model_reset();
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      step(2'b00, 32'h0, 32'h0);

      // Port 1 raises then withdraws while port 0 holds priority.
      step(2'b01, 32'h0000_0080, 32'h0000_0300);
      step(2'b11, 32'h0000_0084, 32'h0000_0300);
      step(2'b01, 32'h0000_0088, 32'h0000_0300);
      step(2'b00, 32'h0, 32'h0);

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         step(2'($urandom_range(0, 3)), rand_addr(), rand_addr());
      end
      step(2'b00, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bootrom_arbiter
`default_nettype wire

// File: doc/bootrom_arbiter.md
BOOTROM_ARBITER -- requirements
Module: bootrom_arbiter

Interface
REQ-001: The block SHALL have parameter N_PORTS, default 2, giving the number of requesters (range 2..8).
REQ-002: The block SHALL have parameter ADDR_WIDTH, default 32, giving the width of the requester byte address.
REQ-003: The block SHALL have parameter DATA_WIDTH, default 32, giving the data width of the ROM and the requesters.
REQ-004: The block SHALL have parameter ROM_WORDS, default 2048, giving the ROM depth in words; ROM_AW = clog2(ROM_WORDS).
REQ-005: Port CLK, input, 1 bit: the single clock; all state is rising-edge.
REQ-006: Port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-007: Port req_i, input, N_PORTS bits: per-port read request.
REQ-008: Port addr_i, input, N_PORTS x ADDR_WIDTH bits: per-port byte address.
REQ-009: Port gnt_o, output, N_PORTS bits: per-port grant, combinational.
REQ-010: Port rvalid_o, output, N_PORTS bits: per-port response valid, registered.
REQ-011: Port rdata_o, output, DATA_WIDTH bits: response data, shared by all ports and qualified by rvalid_o.
REQ-012: Port err_o, output, 1 bit: out-of-range flag, qualified by rvalid_o.
REQ-013: Port rom_cen_o, output, 1 bit: ROM chip enable, active-low.
REQ-014: Port rom_addr_o, output, ROM_AW bits: ROM word address.
REQ-015: Port rom_rdata_i, input, DATA_WIDTH bits: ROM read data, valid one cycle after an enabled access.

Function
REQ-016: At most one gnt_o bit SHALL be high per cycle; a grant is issued in the same cycle whenever any req_i bit is high, so there are no idle stalls.
REQ-017: A requester SHALL hold req_i and addr_i stable until granted; dropping req_i before the grant withdraws the request, with no side effects.
REQ-018: A granted address SHALL be in range when its word address addr_i[ADDR_WIDTH-1:2] is below ROM_WORDS; the low two address bits are ignored.
REQ-019: A granted, in-range access SHALL drive rom_cen_o=0 and rom_addr_o=addr[ROM_AW+1:2] in the grant cycle.
REQ-020: A granted, out-of-range access SHALL keep rom_cen_o=1.
REQ-021: With no grant in a cycle, rom_cen_o SHALL be 1 and rom_addr_o SHALL hold its previous value.
REQ-022: A response register SHALL capture {valid, port index, error} at each grant.
REQ-023: Exactly one cycle after a grant, rvalid_o[index] SHALL be 1 for one cycle.
REQ-024: With a response, rdata_o SHALL be rom_rdata_i when error=0, and rdata_o=0 with err_o=1 when error=1.
REQ-025: When no response is valid, rdata_o SHALL be 0 and err_o SHALL be 0.
REQ-026: Back-to-back grants SHALL give one response per cycle, in grant order, with latency fixed at 1.
REQ-027: Arbitration SHALL be fixed priority, lowest index first, unless the BOOTROM_ARB_RR_EN macro is defined (see Configuration).
REQ-028: A request and its response on the same port in the same cycle are independent and SHALL both proceed.

Reset
REQ-029: While RSTN=0, outputs SHALL be gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, rom_cen_o=1 and rom_addr_o=0.
REQ-030: While RSTN=0, the response register SHALL be invalid and the round-robin pointer SHALL be 0.
REQ-031: Reset asserted mid-access SHALL drop the pending response, with no rvalid_o after reset is released.
REQ-032: The first grant SHALL be possible in the first cycle with RSTN=1.

Configuration
REQ-033: With BOOTROM_ARB_RR_EN defined, arbitration SHALL be round-robin.
REQ-034: In round-robin mode, a pointer register SHALL hold the highest-priority index; after each grant to port k it becomes (k+1) mod N_PORTS, and it is unchanged when there is no grant.
REQ-035: In round-robin mode, a port with continuous requests SHALL be granted within N_PORTS cycles.
REQ-036: Without BOOTROM_ARB_RR_EN, the pointer SHALL be absent, priority SHALL be static, and port 0 can starve the others.

Structure
REQ-037: A shared package bootrom_arb_pkg SHALL hold the response-register struct type {valid, idx, err}, the ROM_WORDS default and the word-offset constant 2.
REQ-038: A sub-module bootrom_arb_prio SHALL contain the combinational priority encoder (request vector and start pointer in, one-hot grant and index out), and it is reused by both configurations.

Verification
REQ-039: Reset release, then req_i=01 with addr 0x0000_0010 -> gnt_o=01 in the same cycle, rom_addr_o=4, rom_cen_o=0, and next cycle rvalid_o=01 with rdata_o=rom_rdata_i and err_o=0.
REQ-040: Both ports request continuously with the macro undefined -> port 0 is granted every cycle and port 1 never.
REQ-041: Both ports request continuously with BOOTROM_ARB_RR_EN defined -> grants alternate 01,10,01,10 and responses follow one cycle later in the same order.
REQ-042: addr 0x0000_2000 (word 2048) -> grant with rom_cen_o=1, and next cycle rvalid_o set, err_o=1, rdata_o=0.
REQ-043: RSTN pulsed low for one cycle between a grant and its response -> no rvalid_o follows and all outputs are at their reset values.
REQ-044: Port 1 raises then drops req_i while port 0 holds priority -> port 1 is never granted and no spurious response occurs.
